// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// selects and the per-stage destination/source tag.
package hazard_pkg;

    localparam int TAG_RD_W = 5;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                reg_write;
        logic                mem_read;
        logic [TAG_RD_W-1:0] rs1;
        logic [TAG_RD_W-1:0] rs2;
        logic                use_rs1;
        logic                use_rs2;
    } tag_t;

    // x0 is hard-wired to zero, so a tag targeting it never produces a value.
    function automatic logic produces(input tag_t t, input logic [TAG_RD_W-1:0] r);
        return t.valid && t.reg_write && (t.rd != '0) && (t.rd == r);
    endfunction

endpackage

// File: rtl/forward_select.sv
// EX-operand source select for one operand; the MEM producer outranks WB
// because it carries the younger value.
import hazard_pkg::*;

module forward_select (
    input  logic [TAG_RD_W-1:0] src_rs,
    input  logic                src_use,
    input  tag_t                mem_tag,
    input  tag_t                wb_tag,
    output logic [1:0]          sel
);

    logic unused_fields;
    assign unused_fields = ^{mem_tag.mem_read, mem_tag.rs1, mem_tag.rs2, mem_tag.use_rs1,
                             mem_tag.use_rs2, wb_tag.mem_read, wb_tag.rs1, wb_tag.rs2,
                             wb_tag.use_rs1, wb_tag.use_rs2};

    always_comb begin
        sel = FWD_RF;
        if (src_use && produces(wb_tag, src_rs)) sel = FWD_MEMWB;
        if (src_use && produces(mem_tag, src_rs)) sel = FWD_EXMEM;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, taken-branch flush and EX forwarding control for a
// five-stage RV32I pipeline, driven from a private tag pipeline.
//
//  state      | meaning
//  RUN        | normal issue; hazards and branches evaluated each cycle
//  LOAD_STALL | one cycle after a load-use bubble; load now in MEM
//  FLUSH      | one idle cycle after a taken branch squashed IF/ID/EX
import hazard_pkg::*;

module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  branch_taken,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  bubble_id_ex,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_mem,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    state_t state, state_nxt;
    tag_t   id_tag, ex_tag, mem_tag, wb_tag;
    logic   load_use, stall, flush;

    always_comb begin
        id_tag           = '0;
        id_tag.valid     = id_valid;
        id_tag.rd        = id_rd;
        id_tag.reg_write = id_reg_write;
        id_tag.mem_read  = id_mem_read;
        id_tag.rs1       = id_rs1;
        id_tag.rs2       = id_rs2;
        id_tag.use_rs1   = id_use_rs1;
        id_tag.use_rs2   = id_use_rs2;
    end

    assign load_use = id_valid && ex_tag.valid && ex_tag.mem_read && (ex_tag.rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_tag.rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_tag.rd)));

    // Branch outranks the stall; RESET silences every control output.
    always_comb begin
        state_nxt = RUN;
        stall     = 1'b0;
        flush     = 1'b0;
        if (branch_taken) begin
            flush     = 1'b1;
            state_nxt = FLUSH;
        end else if ((state != FLUSH) && load_use) begin
            stall     = 1'b1;
            state_nxt = LOAD_STALL;
        end
        if (RESET) begin
            stall = 1'b0;
            flush = 1'b0;
        end
    end

    assign stall_pc     = stall;
    assign stall_if_id  = stall;
    assign bubble_id_ex = stall;
    assign flush_if_id  = flush;
    assign flush_id_ex  = flush;
    assign flush_ex_mem = flush;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= RUN;
            ex_tag      <= '0;
            mem_tag     <= '0;
            wb_tag      <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state  <= state_nxt;
            wb_tag <= mem_tag;
            if (flush) begin
                ex_tag  <= '0;
                mem_tag <= '0;
            end else if (stall) begin
                ex_tag  <= '0;
                mem_tag <= ex_tag;
            end else begin
                ex_tag  <= id_tag;
                mem_tag <= ex_tag;
            end
            if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
            if (flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
        end
    end

    forward_select u_fwd_a (
        .src_rs  (ex_tag.rs1),
        .src_use (ex_tag.use_rs1),
        .mem_tag (mem_tag),
        .wb_tag  (wb_tag),
        .sel     (fwd_a)
    );

    forward_select u_fwd_b (
        .src_rs  (ex_tag.rs2),
        .src_use (ex_tag.use_rs2),
        .mem_tag (mem_tag),
        .wb_tag  (wb_tag),
        .sel     (fwd_b)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven, scoreboarded bench for pipeline_hazard_ctrl; one vector per clock.
import hazard_pkg::*;

module tb_pipeline_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, branch_taken;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count, flush_count;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count), .flush_count(flush_count)
    );

    typedef struct {
        string       name;
        logic        rst, idv, u1, u2, rw, mr, br;
        logic [4:0]  rs1, rs2, rd;
        logic [5:0]  ctrl;   // {stall_pc, stall_if_id, bubble, flush_if_id, flush_id_ex, flush_ex_mem}
        logic [1:0]  fa, fb;
        logic [15:0] sc, fc;
        state_t      st;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_STALL = 6'b111000;
    localparam logic [5:0] C_FLUSH = 6'b000111;

    function automatic vec_t mk(string nm, logic rst, logic idv, logic [4:0] rs1, logic u1,
                                logic [4:0] rs2, logic u2, logic [4:0] rd, logic rw, logic mr,
                                logic br, logic [5:0] ctrl, logic [1:0] fa, logic [1:0] fb,
                                logic [15:0] sc, logic [15:0] fc, state_t st);
        vec_t v;
        v.name = nm; v.rst = rst; v.idv = idv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.rw = rw; v.mr = mr; v.br = br; v.ctrl = ctrl; v.fa = fa; v.fb = fb;
        v.sc = sc; v.fc = fc; v.st = st;
        return v;
    endfunction

    function automatic vec_t idle(string nm, logic [1:0] fa, logic [1:0] fb,
                                  logic [15:0] sc, logic [15:0] fc, state_t st);
        return mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, fa, fb, sc, fc, st);
    endfunction

    task automatic drive(input vec_t v);
        RESET = v.rst; id_valid = v.idv; id_rs1 = v.rs1; id_use_rs1 = v.u1;
        id_rs2 = v.rs2; id_use_rs2 = v.u2; id_rd = v.rd; id_reg_write = v.rw;
        id_mem_read = v.mr; branch_taken = v.br;
    endtask

    task automatic check_one();
        vec_t e;
        logic [5:0] ctrl;
        e = exp_q.pop_front();
        ctrl = {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem};
        n_vec++;
        if (ctrl !== e.ctrl) begin
            n_err++; $display("FAIL %s ctrl: got %b want %b", e.name, ctrl, e.ctrl);
        end
        if (fwd_a !== e.fa) begin
            n_err++; $display("FAIL %s fwd_a: got %0d want %0d", e.name, fwd_a, e.fa);
        end
        if (fwd_b !== e.fb) begin
            n_err++; $display("FAIL %s fwd_b: got %0d want %0d", e.name, fwd_b, e.fb);
        end
        if (stall_count !== e.sc) begin
            n_err++; $display("FAIL %s stall_count: got %h want %h", e.name, stall_count, e.sc);
        end
        if (flush_count !== e.fc) begin
            n_err++; $display("FAIL %s flush_count: got %h want %h", e.name, flush_count, e.fc);
        end
        if (dut.state !== e.st) begin
            n_err++; $display("FAIL %s state: got %0d want %0d", e.name, dut.state, e.st);
        end
    endtask

    task automatic step(input vec_t v);
        drive(v);
        exp_q.push_back(v);
        @(negedge CLK);
        check_one();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // load-use, then ALU forwarding (EX/MEM, MEM/WB), x0, branch vs stall, MEM priority
        tbl.push_back(mk("reset",        1,0, 0,0, 0,0,  0,0,0, 0, C_NONE,  0,0, 0,0, RUN));
        tbl.push_back(mk("lw_x5",        0,1, 2,1, 0,0,  5,1,1, 0, C_NONE,  0,0, 0,0, RUN));
        tbl.push_back(mk("load_use",     0,1, 5,1, 7,1,  6,1,0, 0, C_STALL, 0,0, 0,0, RUN));
        tbl.push_back(mk("load_stall",   0,1, 5,1, 7,1,  6,1,0, 0, C_NONE,  0,0, 1,0, LOAD_STALL));
        tbl.push_back(idle("fwd_a_wb_load", 2,0, 1,0, RUN));
        tbl.push_back(mk("add_x3",       0,1, 1,1, 2,1,  3,1,0, 0, C_NONE,  0,0, 1,0, RUN));
        tbl.push_back(mk("sub_rd_x3",    0,1, 8,1, 3,1,  4,1,0, 0, C_NONE,  0,0, 1,0, RUN));
        tbl.push_back(idle("fwd_b_exmem", 0,1, 1,0, RUN));
        tbl.push_back(mk("add_x10",      0,1, 1,1, 2,1, 10,1,0, 0, C_NONE,  0,0, 1,0, RUN));
        tbl.push_back(mk("or_x11",       0,1,12,1,13,1, 11,1,0, 0, C_NONE,  0,0, 1,0, RUN));
        tbl.push_back(mk("and_rd_x10",   0,1,15,1,10,1, 14,1,0, 0, C_NONE,  0,0, 1,0, RUN));
        tbl.push_back(idle("fwd_b_memwb", 0,2, 1,0, RUN));
        tbl.push_back(mk("lw_x0",        0,1, 1,1, 0,0,  0,1,1, 0, C_NONE,  0,0, 1,0, RUN));
        tbl.push_back(mk("x0_no_stall",  0,1, 0,1, 0,1,  7,1,0, 0, C_NONE,  0,0, 1,0, RUN));
        tbl.push_back(idle("x0_no_fwd",   0,0, 1,0, RUN));
        tbl.push_back(idle("idle",        0,0, 1,0, RUN));
        tbl.push_back(mk("lw_x5_b",      0,1, 1,1, 0,0,  5,1,1, 0, C_NONE,  0,0, 1,0, RUN));
        tbl.push_back(mk("br_vs_stall",  0,1, 5,1, 5,1,  6,1,0, 1, C_FLUSH, 0,0, 1,0, RUN));
        tbl.push_back(mk("flush_state",  0,1, 5,1, 6,1,  9,1,0, 0, C_NONE,  0,0, 1,1, FLUSH));
        tbl.push_back(idle("flush_cleared", 0,0, 1,1, RUN));
        tbl.push_back(mk("add_x20_a",    0,1, 1,1, 0,0, 20,1,0, 0, C_NONE,  0,0, 1,1, RUN));
        tbl.push_back(mk("add_x20_b",    0,1, 1,1, 0,0, 20,1,0, 0, C_NONE,  0,0, 1,1, RUN));
        tbl.push_back(mk("reader_x20",   0,1,20,1,20,1, 21,1,0, 0, C_NONE,  0,0, 1,1, RUN));
        tbl.push_back(idle("fwd_mem_prio", 1,1, 1,1, RUN));

        drive(mk("init", 1,0, 0,0, 0,0, 0,0,0, 0, C_NONE, 0,0, 0,0, RUN));
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // reset asserted while in LOAD_STALL, with a branch pending to check gating
        step(mk("rs_lw_x5",    0,1, 1,1, 0,0, 5,1,1, 0, C_NONE,  0,0, 1,1, RUN));
        step(mk("rs_load_use", 0,1, 5,1, 0,0, 6,1,0, 0, C_STALL, 0,0, 1,1, RUN));
        step(mk("rs_assert",   1,1, 5,1, 0,0, 6,1,0, 1, C_NONE,  0,0, 2,1, LOAD_STALL));
        step(idle("rs_held", 0,0, 0,0, RUN) );
        step(mk("rs_release",  0,1, 5,1, 5,1, 6,1,0, 0, C_NONE,  0,0, 0,0, RUN));
        step(idle("rs_no_stale_fwd", 0,0, 0,0, RUN));

        // flush counter saturation
        drive(mk("sat", 0,0, 0,0, 0,0, 0,0,0, 1, C_NONE, 0,0, 0,0, RUN));
        repeat (65537) @(posedge CLK);
        #1;
        step(idle("sat_hold", 0,0, 0,16'hFFFF, FLUSH));
        step(mk("sat_branch", 0,0, 0,0, 0,0, 0,0,0, 1, C_FLUSH, 0,0, 0,16'hFFFF, RUN));
        step(idle("sat_no_wrap", 0,0, 0,16'hFFFF, FLUSH));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard controller for the five-stage RV32I pipeline (IF, ID, EX, MEM, WB). It tracks the destination register of every in-flight instruction in its own tag pipeline. From those tags it produces load-use stalls, taken-branch flushes and EX-stage forwarding selects. It sits beside the stage registers and drives their hold, bubble and flush controls; it never touches datapath values.

## Interface
- `REG_ADDR_W`, 5, register index width
- `CNT_W`, 16, width of saturating performance counters
- `CLK`  in  1  clock, rising edge
- `RESET`  in  1  synchronous, active-high reset
- `id_valid`  in  1  ID stage holds a real instruction
- `id_rs1`, `id_rs2`  in  `REG_ADDR_W`  source registers of the ID instruction
- `id_use_rs1`, `id_use_rs2`  in  1  ID instruction actually reads rs1 / rs2
- `id_rd`  in  `REG_ADDR_W`  destination of the ID instruction
- `id_reg_write`  in  1  ID instruction writes rd
- `id_mem_read`  in  1  ID instruction is a load
- `branch_taken`  in  1  taken branch/jump resolved in MEM this cycle (PCSrc)
- `stall_pc`  out  1  hold PC
- `stall_if_id`  out  1  hold IF/ID register
- `bubble_id_ex`  out  1  load NOP controls into ID/EX
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem`  out  1  invalidate that stage register
- `fwd_a`, `fwd_b`  out  2  EX operand source: 0 regfile, 1 EX/MEM result, 2 MEM/WB result
- `stall_count`, `flush_count`  out  `CNT_W`  saturating event counters

## Operation
- Tag pipeline: three tag registers, EX, MEM and WB. Each holds valid, rd, reg_write, mem_read, rs1, rs2, use_rs1 and use_rs2.
- Each unstalled cycle, the tags shift ID→EX→MEM→WB.
- A tag with rd = 0 is treated as non-writing.
- FSM states, encoded in the package:
  - RUN: normal operation.
  - LOAD_STALL: exactly one cycle.
  - FLUSH: exactly one cycle.
- Load-use hazard is `id_valid` AND EX.valid AND EX.mem_read AND EX.rd ≠ 0, AND either (`id_use_rs1` AND `id_rs1` = EX.rd) or (`id_use_rs2` AND `id_rs2` = EX.rd).
- RUN with load-use hazard and no `branch_taken`:
  - Assert `stall_pc`, `stall_if_id` and `bubble_id_ex`.
  - The EX tag becomes invalid; MEM and WB shift normally.
  - Next state is LOAD_STALL.
- LOAD_STALL:
  - No stall outputs are asserted (the load is now in MEM; forwarding covers it).
  - Normal shift.
  - Next state is RUN, unless a new hazard or branch is detected (evaluated as in RUN).
- `branch_taken`, in any state:
  - Assert all three flush outputs.
  - Clear the EX and MEM tag valids, and clear the incoming ID tag (EX becomes invalid). WB still receives the old MEM tag.
  - Next state is FLUSH.
- FLUSH: outputs idle; next state is RUN.
- Branch priority: `branch_taken` wins over a simultaneous load-use hazard. No stall is asserted and `stall_count` does not increment.
- Forwarding for EX operand A (operand B is identical using rs2):
  - 1 if MEM.valid AND MEM.reg_write AND MEM.rd ≠ 0 AND MEM.rd = EX.rs1 AND EX.use_rs1.
  - Otherwise 2 under the same test on WB.
  - Otherwise 0.
  - MEM has priority over WB.
- Counters:
  - `stall_count` increments on each cycle with `stall_pc`.
  - `flush_count` increments on each cycle with `branch_taken`.
  - Both saturate at all-ones.

## Timing
- `stall_*`, `bubble_id_ex` and `flush_*` are combinational (Mealy) from the current inputs and registered tags/state, and are valid in the same cycle as the inputs.
- `fwd_a` and `fwd_b` are combinational from registered tags only.
- Tags, state and counters update on the rising edge of `CLK`.
- Latency: a hazard is detected in ID and the stall is applied at that cycle's edge. One bubble is inserted per load-use.
- Reset, including mid-stall or mid-flush:
  - All tag valids are 0, state is RUN, counters are 0.
  - All outputs are 0 in the cycle after `RESET` is sampled high, and remain 0 while it is held.

## Structure
- `hazard_pkg`: the FSM state enum (RUN, LOAD_STALL, FLUSH), the forwarding-select constants (FWD_RF, FWD_EXMEM, FWD_MEMWB) and the tag struct type.
- One sub-module, `forward_select`. It is combinational: inputs are the EX source fields plus one producer tag pair (MEM and WB); output is the 2-bit select. It is instantiated once per operand.

## Test plan
- Load followed by a dependent instruction. The EX tag is a valid load with rd=5; ID has rs1=5 with `id_use_rs1`=1.
  - Required: `stall_pc`, `stall_if_id` and `bubble_id_ex` are 1 for exactly one cycle, then state is LOAD_STALL, then RUN.
  - Required: on the next cycle `fwd_a`=2; `stall_count`=1.
- ALU back-to-back. `add x3`, then `sub` reading x3 as rs2.
  - Required: no stall, and `fwd_b`=1 when the `sub` is in EX.
  - With one independent instruction between them: `fwd_b`=2.
- x0 destination. A load to rd=0 is followed by a reader of x0.
  - Required: no stall; `fwd_a`=`fwd_b`=0.
- Simultaneous events. `branch_taken`=1 in the same cycle as a load-use hazard.
  - Required: the three flush outputs are 1 and the stall outputs are 0; `flush_count`=1 and `stall_count`=0; the EX and MEM tags are invalid on the next cycle.
- Reset mid-operation. Assert `RESET` during LOAD_STALL.
  - Required: all outputs and counters are 0 on the following cycle and state is RUN.
  - Required: after release, a stale EX tag produces no forwarding.
- Counter saturation. Preload via 2^`CNT_W` flushes.
  - Required: `flush_count` holds at 16'hFFFF and does not wrap.
